// File: rtl/lsu_pkg.sv
// rtl/lsu_pkg.sv - load/store size encodings, FSM states and defaults
package lsu_pkg;

  localparam logic [2:0] LS_B  = 3'b000;
  localparam logic [2:0] LS_H  = 3'b001;
  localparam logic [2:0] LS_W  = 3'b010;
  localparam logic [2:0] LS_BU = 3'b100;
  localparam logic [2:0] LS_HU = 3'b101;

  localparam int TIMEOUT_CYCLES_DEF = 64;

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DONE} lsu_state_e;
  typedef enum logic [1:0] {SZ_B, SZ_H, SZ_W} lsu_size_e;

  // Unused encodings fall through to word access.
  function automatic lsu_size_e size_of(input logic [2:0] sel);
    case (sel)
      LS_B, LS_BU: size_of = SZ_B;
      LS_H, LS_HU: size_of = SZ_H;
      LS_W:        size_of = SZ_W;
      default:     size_of = SZ_W;
    endcase
  endfunction

endpackage

// File: rtl/lsu_align.sv
// rtl/lsu_align.sv - misalign check, byte enables, store lane replication, load extraction
module lsu_align
  import lsu_pkg::*;
(
  input  logic [2:0]  sel,
  input  logic [1:0]  off,
  input  logic [31:0] wdata,
  input  logic [31:0] rdata,
  output logic        misalign,
  output logic [3:0]  be,
  output logic [31:0] wdata_lane,
  output logic [31:0] rdata_ext
);

  lsu_size_e   size;
  logic [7:0]  byte_v;
  logic [15:0] half_v;

  always_comb begin
    size       = size_of(sel);
    byte_v     = rdata[{off, 3'b000} +: 8];
    half_v     = off[1] ? rdata[31:16] : rdata[15:0];
    misalign   = 1'b0;
    be         = 4'b1111;
    wdata_lane = wdata;
    rdata_ext  = rdata;
    case (size)
      SZ_B: begin
        be         = 4'b0001 << off;
        wdata_lane = {4{wdata[7:0]}};
        rdata_ext  = {{24{~sel[2] & byte_v[7]}}, byte_v};
      end
      SZ_H: begin
        misalign   = off[0];
        be         = 4'b0011 << {off[1], 1'b0};
        wdata_lane = {2{wdata[15:0]}};
        rdata_ext  = {{16{~sel[2] & half_v[15]}}, half_v};
      end
      default: misalign = |off;
    endcase
  end

endmodule

// File: rtl/lsu_ctrl.sv
// rtl/lsu_ctrl.sv - load/store bus sequencer; optional watchdog via LSU_TIMEOUT_EN
module lsu_ctrl
  import lsu_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        mem_en_i,
  input  logic        memRW_i,
  input  logic [2:0]  ld_st_sel_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  output logic        stall_o,
  output logic        done_o,
  output logic [31:0] rdata_o,
  output logic        misalign_o,
  output logic        bus_err_o,
  output logic        req_o,
  output logic        we_o,
  output logic [3:0]  be_o,
  output logic [31:0] addr_o,
  output logic [31:0] wdata_o,
  input  logic        gnt_i,
  input  logic        rvalid_i,
  input  logic [31:0] rdata_i
);

  lsu_state_e  state_q, state_d;
  logic        we_q, err_q, stall_d;
  logic [2:0]  sel_q;
  logic [1:0]  off_q;
  logic [3:0]  be_q;
  logic [31:0] addr_q, wdata_q, rdata_q;

  logic        idle, a_mis, accept, handshake, timeout;
  logic [2:0]  a_sel;
  logic [1:0]  a_off;
  logic [3:0]  a_be;
  logic [31:0] a_wdata, a_rdata;

  // In IDLE the aligner sees the live request; afterwards the latched one.
  assign idle  = (state_q == S_IDLE);
  assign a_sel = idle ? ld_st_sel_i : sel_q;
  assign a_off = idle ? addr_i[1:0] : off_q;

  lsu_align u_align (
    .sel        (a_sel),
    .off        (a_off),
    .wdata      (wdata_i),
    .rdata      (rdata_i),
    .misalign   (a_mis),
    .be         (a_be),
    .wdata_lane (a_wdata),
    .rdata_ext  (a_rdata)
  );

  assign accept    = idle && mem_en_i && !a_mis;
  assign handshake = (state_q == S_REQ && gnt_i) || (state_q == S_WAIT && rvalid_i);

`ifdef LSU_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] cnt_q;
  logic          busy;

  assign busy    = (state_q == S_REQ) || (state_q == S_WAIT);
  assign timeout = busy && (cnt_q == CW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk_i) begin
    if (!rst_ni || accept) cnt_q <= '0;
    else if (busy)         cnt_q <= cnt_q + CW'(1);
  end
`else
  localparam int unused_timeout_cycles = TIMEOUT_CYCLES;
  assign timeout = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    stall_d = 1'b0;
    case (state_q)
      S_IDLE: if (accept) begin
        state_d = S_REQ;
        stall_d = 1'b1;
      end
      S_REQ: begin
        stall_d = 1'b1;
        if (gnt_i)        state_d = we_q ? S_DONE : S_WAIT;
        else if (timeout) state_d = S_DONE;
      end
      S_WAIT: begin
        stall_d = 1'b1;
        if (rvalid_i || timeout) state_d = S_DONE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= S_IDLE;
      we_q    <= 1'b0;
      err_q   <= 1'b0;
      sel_q   <= '0;
      off_q   <= '0;
      be_q    <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        we_q    <= memRW_i;
        err_q   <= 1'b0;
        sel_q   <= ld_st_sel_i;
        off_q   <= addr_i[1:0];
        be_q    <= a_be;
        addr_q  <= {addr_i[31:2], 2'b00};
        wdata_q <= a_wdata;
      end
      if (state_q == S_WAIT && rvalid_i) begin
        rdata_q <= a_rdata;
      end else if (timeout && !handshake) begin
        rdata_q <= '0;
        err_q   <= 1'b1;
      end
    end
  end

  assign stall_o    = stall_d && rst_ni;
  assign misalign_o = idle && mem_en_i && a_mis && rst_ni;
  assign req_o      = (state_q == S_REQ);
  assign we_o       = req_o && we_q;
  assign be_o       = be_q;
  assign addr_o     = addr_q;
  assign wdata_o    = wdata_q;
  assign done_o     = (state_q == S_DONE);
  assign bus_err_o  = done_o && err_q;
  assign rdata_o    = rdata_q;

endmodule

// File: tb/tb_lsu_ctrl.sv
// tb/tb_lsu_ctrl.sv - directed self-checking bench for lsu_ctrl
module tb_lsu_ctrl;

  logic        clk = 1'b0;
  logic        rst_n, mem_en, mem_rw, gnt, rvalid;
  logic [2:0]  ld_st_sel;
  logic [31:0] addr, wdata, bus_rdata;
  logic        stall, done, misalign, bus_err, req, we;
  logic [3:0]  be;
  logic [31:0] rdata, bus_addr, bus_wdata;
  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  lsu_ctrl #(.TIMEOUT_CYCLES(4)) dut (
    .clk_i(clk), .rst_ni(rst_n), .mem_en_i(mem_en), .memRW_i(mem_rw),
    .ld_st_sel_i(ld_st_sel), .addr_i(addr), .wdata_i(wdata),
    .stall_o(stall), .done_o(done), .rdata_o(rdata), .misalign_o(misalign),
    .bus_err_o(bus_err), .req_o(req), .we_o(we), .be_o(be), .addr_o(bus_addr),
    .wdata_o(bus_wdata), .gnt_i(gnt), .rvalid_i(rvalid), .rdata_i(bus_rdata)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic do_store(input string tag, input logic [2:0] sel, input logic [31:0] a,
                          input logic [31:0] wd, input logic [31:0] exp_addr,
                          input logic [3:0] exp_be, input logic [31:0] exp_wd, input int gdly);
    mem_en = 1; mem_rw = 1; ld_st_sel = sel; addr = a; wdata = wd;
    #1 chk({tag, ":stall_idle"}, stall, 1);
    tick();
    repeat (gdly) begin
      #1 chk({tag, ":req_wait"}, req, 1);
      tick();
    end
    gnt = 1;
    #1;
    chk({tag, ":req"}, req, 1);
    chk({tag, ":we"}, we, 1);
    chk({tag, ":be"}, be, exp_be);
    chk({tag, ":addr_o"}, bus_addr, exp_addr);
    chk({tag, ":wdata_o"}, bus_wdata, exp_wd);
    chk({tag, ":stall_req"}, stall, 1);
    tick();
    gnt = 0; mem_en = 0;
    #1;
    chk({tag, ":done"}, done, 1);
    chk({tag, ":stall_done"}, stall, 0);
    chk({tag, ":req_done"}, req, 0);
    tick();
  endtask

  task automatic do_load(input string tag, input logic [2:0] sel, input logic [31:0] a,
                         input logic [31:0] rd, input int gdly, input int rdly,
                         input bit noise, input logic [31:0] exp);
    mem_en = 1; mem_rw = 0; ld_st_sel = sel; addr = a;
    #1 chk({tag, ":stall_idle"}, stall, 1);
    tick();
    repeat (gdly) begin
      rvalid = noise; bus_rdata = 32'hDEADBEEF;
      #1 chk({tag, ":req_wait"}, req, 1);
      tick();
    end
    gnt = 1; rvalid = noise; bus_rdata = 32'hDEADBEEF;
    #1 chk({tag, ":req_gnt"}, req, 1);
    tick();
    gnt = 0; rvalid = 0;
    repeat (rdly) begin
      #1 chk({tag, ":done_early"}, done, 0);
      tick();
    end
    rvalid = 1; bus_rdata = rd;
    #1;
    chk({tag, ":stall_wait"}, stall, 1);
    chk({tag, ":done_wait"}, done, 0);
    tick();
    rvalid = 0; mem_en = 0; bus_rdata = 32'h0;
    #1;
    chk({tag, ":done"}, done, 1);
    chk({tag, ":rdata"}, rdata, exp);
    chk({tag, ":bus_err"}, bus_err, 0);
    chk({tag, ":stall_done"}, stall, 0);
    tick();
  endtask

  initial begin
    rst_n = 0; mem_en = 1; mem_rw = 0; ld_st_sel = 3'b010; addr = 32'h0;
    wdata = 32'h0; gnt = 0; rvalid = 0; bus_rdata = 32'h0;
    tick(); tick();
    chk("rst:stall_forced", stall, 0);
    chk("rst:req", req, 0);
    chk("rst:we", we, 0);
    chk("rst:done", done, 0);
    chk("rst:misalign", misalign, 0);
    chk("rst:bus_err", bus_err, 0);
    chk("rst:be", be, 0);
    chk("rst:addr_o", bus_addr, 0);
    chk("rst:wdata_o", bus_wdata, 0);
    chk("rst:rdata", rdata, 0);
    mem_en = 0; rst_n = 1;
    tick();

    do_store("sb", 3'b000, 32'h0000_1003, 32'h0000_00A5, 32'h0000_1000, 4'b1000, 32'hA5A5A5A5, 0);
    do_store("sh", 3'b001, 32'h0000_1002, 32'h1234_BEEF, 32'h0000_1000, 4'b1100, 32'hBEEFBEEF, 1);
    do_store("sw", 3'b010, 32'h0000_100C, 32'h1234_5678, 32'h0000_100C, 4'b1111, 32'h12345678, 0);

    do_load("lh",  3'b001, 32'h0000_2002, 32'h8001_1234, 2, 0, 0, 32'hFFFF8001);
    do_load("lhu", 3'b101, 32'h0000_2002, 32'h8001_1234, 2, 0, 0, 32'h00008001);
    do_load("lh0", 3'b001, 32'h0000_2000, 32'h8001_1234, 0, 0, 0, 32'h00001234);
    do_load("lb1", 3'b000, 32'h0000_2001, 32'h8001_1234, 0, 0, 0, 32'h00000012);
    do_load("lb3", 3'b000, 32'h0000_2003, 32'h8001_1234, 0, 0, 0, 32'hFFFFFF80);
    do_load("lbu", 3'b100, 32'h0000_2003, 32'h8001_1234, 0, 0, 0, 32'h00000080);
    do_load("lw_noise", 3'b010, 32'h0000_2000, 32'h8001_1234, 1, 1, 1, 32'h80011234);
    do_load("lw_sel7", 3'b111, 32'h0000_2004, 32'hCAFE_F00D, 0, 0, 0, 32'hCAFEF00D);

    do_store("sb_hold", 3'b000, 32'h0000_1000, 32'h0000_0011, 32'h0000_1000, 4'b0001, 32'h11111111, 0);
    chk("store_keeps_rdata", rdata, 32'hCAFEF00D);

    mem_en = 1; mem_rw = 0; ld_st_sel = 3'b010; addr = 32'h0000_3001;
    #1;
    chk("mis_lw:misalign", misalign, 1);
    chk("mis_lw:stall", stall, 0);
    tick();
    chk("mis_lw:req", req, 0);
    ld_st_sel = 3'b001; addr = 32'h0000_3001;
    #1 chk("mis_lh:misalign", misalign, 1);
    tick();
    ld_st_sel = 3'b011; addr = 32'h0000_3002;
    #1 chk("mis_sel3:misalign", misalign, 1);
    tick();
    mem_en = 0;
    #1;
    chk("mis:req_never", req, 0);
    chk("mis:misalign_clear", misalign, 0);
    tick();

    mem_en = 1; mem_rw = 0; ld_st_sel = 3'b010; addr = 32'h0000_4000;
    tick();
    gnt = 1;
    tick();
    gnt = 0; rst_n = 0;
    #1 chk("rst_mid:stall_forced", stall, 0);
    tick();
    chk("rst_mid:req", req, 0);
    chk("rst_mid:done", done, 0);
    chk("rst_mid:be", be, 0);
    chk("rst_mid:addr_o", bus_addr, 0);
    chk("rst_mid:rdata", rdata, 0);
    rst_n = 1; mem_en = 0; rvalid = 1; bus_rdata = 32'h5555_5555;
    tick();
    chk("rst_mid:late_rvalid_done", done, 0);
    chk("rst_mid:late_rvalid_req", req, 0);
    rvalid = 0;
    tick();
    chk("rst_mid:late_rvalid_rdata", rdata, 0);

`ifdef LSU_TIMEOUT_EN
    mem_en = 1; mem_rw = 0; ld_st_sel = 3'b010; addr = 32'h0000_5000;
    tick();
    repeat (3) begin
      chk("to:req_held", req, 1);
      tick();
    end
    chk("to:req_last", req, 1);
    tick();
    mem_en = 0;
    #1;
    chk("to:done", done, 1);
    chk("to:bus_err", bus_err, 1);
    chk("to:rdata", rdata, 0);
    chk("to:req_dropped", req, 0);
    tick();
    chk("to:bus_err_pulse", bus_err, 0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/lsu_ctrl.md
# lsu_ctrl

Load/store sequencer between the RV32I core datapath and the data-memory bus. Takes the memory-op controls produced by instruction decode (memRW, ld_st_sel, wb_sel = memory), stalls the core while it runs a req/gnt/rvalid bus transaction, generates byte enables and lane-replicated write data, and returns a sign/zero-extended load result. Also flags misaligned accesses to the trap logic.

## Interface
- `TIMEOUT_CYCLES`, default 64: bus watchdog limit in cycles. Used only with `LSU_TIMEOUT_EN`.
- `clk_i` input 1: the single clock.
- `rst_ni` input 1: reset, synchronous, active-low.
- `mem_en_i` input 1: the current instruction is a load or store. Held stable by the core while `stall_o`=1.
- `memRW_i` input 1: 1 = store, 0 = load.
- `ld_st_sel_i` input 3: size/sign select. 000 B, 001 H, 010 W, 100 BU, 101 HU.
- `addr_i` input 32: byte address from the ALU.
- `wdata_i` input 32: rs2 store data.
- `stall_o` output 1: freezes the PC and pipeline.
- `done_o` output 1: one-cycle completion pulse.
- `rdata_o` output 32: extended load data. Valid while `done_o`=1, and held until the next load completes.
- `misalign_o` output 1: one-cycle pulse for a misaligned access. No bus access is made for it.
- `bus_err_o` output 1: one-cycle pulse marking a timeout completion.
- `req_o` output 1: bus request.
- `we_o` output 1: bus write enable.
- `be_o` output 4: bus byte enables.
- `addr_o` output 32: word-aligned address, with [1:0]=00.
- `wdata_o` output 32: bus write data.
- `gnt_i` input 1: bus grant.
- `rvalid_i` input 1: bus read data valid.
- `rdata_i` input 32: bus read data.

## Operation
- **FSM states:** IDLE, REQ, WAIT, DONE.
- **IDLE:**
  - `mem_en_i`=1 and aligned: latch the bus fields, then go to REQ. `stall_o`=1 combinationally in this cycle.
  - `mem_en_i`=1 and misaligned: `misalign_o`=1 and `stall_o`=0 in this cycle. Stay in IDLE.
- **REQ:** `req_o`=1 with `we_o`/`be_o`/`addr_o`/`wdata_o` stable until `gnt_i`. On `gnt_i`, a store goes to DONE and a load goes to WAIT.
- **WAIT:** on `rvalid_i`, register the extended `rdata_i` into `rdata_o` and go to DONE.
- **DONE:** `stall_o`=0, `done_o`=1, then go to IDLE. The core retires the instruction at this edge.
- `stall_o` is 1 in REQ and WAIT, and 0 in DONE. It is forced to 0 while `rst_ni`=0.
- **Misalignment:**
  - H/HU with addr[0]=1.
  - W with addr[1:0]≠00.
  - Byte accesses never misalign.
- **Undefined sizes:** encodings 011, 110 and 111 are treated as W.
- **Byte enables:**
  - B: 0001<<addr[1:0].
  - H: 0011<<{addr[1],1'b0}.
  - W: 1111.
- **Write data:**
  - SB: {4{wdata_i[7:0]}}.
  - SH: {2{wdata_i[15:0]}}.
  - SW: wdata_i.
- **Load data:** select the byte lane by addr[1:0] or the half lane by addr[1]. Sign-extend unless ld_st_sel[2]=1.
- **Ignored and boundary conditions:**
  - `rvalid_i` outside WAIT is ignored, including `rvalid_i` in the same cycle as `gnt_i`.
  - `gnt_i` outside REQ is ignored.
  - If `mem_en_i` drops mid-transaction, the transaction still completes with `done_o`.
  - A new `mem_en_i` is accepted only in IDLE, i.e. the cycle after DONE at the earliest.

## Timing
- **Minimum latencies:** with `gnt_i` in the first REQ cycle and `rvalid_i` in the first WAIT cycle:
  - Store: 3 cycles (IDLE, REQ, DONE). `stall_o` is high for 2.
  - Load: 4 cycles (IDLE, REQ, WAIT, DONE).
- Every wait cycle on `gnt_i` or `rvalid_i` adds one cycle.
- **Reset:**
  - Outputs: `req_o`, `we_o`, `done_o`, `misalign_o` and `bus_err_o` are 0. `be_o`, `addr_o`, `wdata_o` and `rdata_o` are 0.
  - State: IDLE.
  - Reset mid-transaction: abandons the transaction at the next edge, and `req_o` drops. No `done_o` is produced.

## Configuration
- **`LSU_TIMEOUT_EN` defined:**
  - A counter is cleared on entry to REQ and counts cycles spent in REQ+WAIT.
  - When it reaches `TIMEOUT_CYCLES`, `req_o` drops, the FSM goes to DONE with `bus_err_o`=1, and `rdata_o`=0.
- **`LSU_TIMEOUT_EN` undefined:** no counter. The FSM waits indefinitely, and `bus_err_o` is tied to 0.

## Structure
- **Package `lsu_pkg`:**
  - `ld_st_sel` encodings `LS_B`, `LS_H`, `LS_W`, `LS_BU`, `LS_HU`.
  - State enum `lsu_state_e`.
  - Default `TIMEOUT_CYCLES`.
- **Sub-module `lsu_align`:** combinational. Provides the misalign check, be/wdata generation and load extraction. It is shared by the FSM top.

## Test plan
- **SB:** addr 0x1003, wdata 0x000000A5, `gnt_i` in the 1st REQ cycle -> `be_o`=1000, `wdata_o`=0xA5A5A5A5, `addr_o`=0x1000, `we_o`=1, `done_o` in cycle 2, `stall_o` high for 2 cycles.
- **LH/LHU:** addr 0x2002, `rdata_i`=0x8001_1234, `gnt_i` delayed 2 cycles -> LH returns 0xFFFF8001 and LHU returns 0x00008001. Total latency is 6 cycles.
- **Misaligned LW:** addr 0x3001 -> `misalign_o` pulse, `req_o` never asserted, `stall_o`=0.
- **Out-of-window handshakes:** a spurious `rvalid_i` in REQ, and `gnt_i`+`rvalid_i` together -> both ignored. The load completes only on the later `rvalid_i` in WAIT.
- **Reset mid-transaction:** `rst_ni`=0 while in WAIT -> all outputs 0 and IDLE after the edge. A late `rvalid_i` is then ignored.
- **Timeout (`LSU_TIMEOUT_EN`, `TIMEOUT_CYCLES`=4):** `gnt_i` never asserted -> `bus_err_o` and `done_o` pulse together, `rdata_o`=0, `req_o` deasserted.
